// File: rtl/pdua_ctrl_pkg.sv
// Shared definitions for the PDUA control unit: FSM states, opcodes,
// ALU operation codes, register-bank map and the decoded-op record.
package pdua_ctrl_pkg;

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_F0   = 3'd1,
    S_F1   = 3'd2,
    S_F2   = 3'd3,
    S_DEC  = 3'd4,
    S_EX   = 3'd5
  } state_t;

  // Opcodes (5-bit IR field)
  localparam logic [4:0] OP_NOP     = 5'b00000;
  localparam logic [4:0] OP_MOV_ACC = 5'b00001;  // ACC <- A
  localparam logic [4:0] OP_MOV_A   = 5'b00010;  // A <- ACC
  localparam logic [4:0] OP_XOR     = 5'b00011;
  localparam logic [4:0] OP_ADD     = 5'b00100;
  localparam logic [4:0] OP_SHL     = 5'b00101;
  localparam logic [4:0] OP_JMP     = 5'b00110;
  localparam logic [4:0] OP_JZ      = 5'b00111;
  localparam logic [4:0] OP_JN      = 5'b01000;

  // ALU operation select; the second ALU operand is always ACC
  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_INC  = 3'b010;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SHL  = 3'b101;

  // Register-bank map
  localparam logic [2:0] REG_PC   = 3'd0;
  localparam logic [2:0] REG_SP   = 3'd1;
  localparam logic [2:0] REG_DPTR = 3'd2;
  localparam logic [2:0] REG_A    = 3'd3;
  localparam logic [2:0] REG_ACC  = 3'd7;

  // Condition that qualifies the bank write in EX
  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_Z    = 2'd1,
    BR_N    = 2'd2
  } br_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] selop;
    logic [1:0] shamt;
    logic [2:0] busb;
    logic [2:0] busc;
    logic       write;
    logic       enaf;
    br_t        br;
  } dec_t;

endpackage

// File: rtl/pdua_ctrl_decode.sv
// Combinational opcode decoder: opcode -> EX-cycle control record.
module pdua_ctrl_decode
  import pdua_ctrl_pkg::*;
#(
  parameter int OP_WIDTH = 5
) (
  input  logic [OP_WIDTH-1:0] i_op,
  output dec_t                o_dec
);

  // Map opcode to its execute-stage action; anything unlisted is invalid
  always_comb begin
    o_dec       = '0;
    o_dec.selop = ALU_PASS;
    o_dec.br    = BR_NONE;
    case (i_op)
      OP_WIDTH'(OP_NOP): begin
        o_dec.valid = 1'b1;
      end
      OP_WIDTH'(OP_MOV_ACC): begin
        o_dec.valid = 1'b1;
        o_dec.busb  = REG_A;
        o_dec.busc  = REG_ACC;
        o_dec.write = 1'b1;
      end
      OP_WIDTH'(OP_MOV_A): begin
        o_dec.valid = 1'b1;
        o_dec.busb  = REG_ACC;
        o_dec.busc  = REG_A;
        o_dec.write = 1'b1;
      end
      OP_WIDTH'(OP_XOR): begin
        o_dec.valid = 1'b1;
        o_dec.selop = ALU_XOR;
        o_dec.busb  = REG_A;
        o_dec.busc  = REG_ACC;
        o_dec.write = 1'b1;
        o_dec.enaf  = 1'b1;
      end
      OP_WIDTH'(OP_ADD): begin
        o_dec.valid = 1'b1;
        o_dec.selop = ALU_ADD;
        o_dec.busb  = REG_A;
        o_dec.busc  = REG_ACC;
        o_dec.write = 1'b1;
        o_dec.enaf  = 1'b1;
      end
      OP_WIDTH'(OP_SHL): begin
        o_dec.valid = 1'b1;
        o_dec.selop = ALU_SHL;
        o_dec.shamt = 2'b01;
        o_dec.busc  = REG_ACC;
        o_dec.write = 1'b1;
        o_dec.enaf  = 1'b1;
      end
      OP_WIDTH'(OP_JMP): begin
        o_dec.valid = 1'b1;
        o_dec.busb  = REG_DPTR;
        o_dec.busc  = REG_PC;
        o_dec.write = 1'b1;
      end
      OP_WIDTH'(OP_JZ): begin
        o_dec.valid = 1'b1;
        o_dec.busb  = REG_DPTR;
        o_dec.busc  = REG_PC;
        o_dec.write = 1'b1;
        o_dec.br    = BR_Z;
      end
      OP_WIDTH'(OP_JN): begin
        o_dec.valid = 1'b1;
        o_dec.busb  = REG_DPTR;
        o_dec.busc  = REG_PC;
        o_dec.write = 1'b1;
        o_dec.br    = BR_N;
      end
      default: o_dec.valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/pdua_ctrl_unit.sv
// PDUA hard-wired control unit: fetch / decode / execute sequencer that
// drives every datapath control input from the current state.
module pdua_ctrl_unit
  import pdua_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int OP_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [OP_WIDTH-1:0]   out_IR,
  input  logic                  C,
  input  logic                  N,
  input  logic                  P,
  input  logic                  Z,
  output logic                  enaf,
  output logic [2:0]            selop,
  output logic [1:0]            shamt,
  output logic                  bank_wr_en,
  output logic [ADDR_WIDTH-1:0] BusB_addr,
  output logic [ADDR_WIDTH-1:0] BusC_addr,
  output logic                  sclr,
  output logic                  ir_en,
  output logic                  mar_en,
  output logic                  mdr_en,
  output logic                  mdr_alu_n,
  output logic                  wr_rdn,
  output logic                  ill_op
);

  state_t              r_state;
  logic [OP_WIDTH-1:0] r_op;
  logic [OP_WIDTH-1:0] w_dec_op;
  dec_t                w_dec;
  logic                w_take;
  logic                w_unused_flags;

  // C and P are not consumed by any current instruction
  assign w_unused_flags = C ^ P;

  // In DEC the IR is decoded directly (legality check); in EX the latched copy
  assign w_dec_op = (r_state == S_DEC) ? out_IR : r_op;

  pdua_ctrl_decode #(.OP_WIDTH(OP_WIDTH)) u_decode (
    .i_op  (w_dec_op),
    .o_dec (w_dec)
  );

  // Branch qualifier on the registered flags, sampled in EX
  always_comb begin
    case (w_dec.br)
      BR_Z:    w_take = Z;
      BR_N:    w_take = N;
      default: w_take = 1'b1;
    endcase
  end

  // State sequencing and opcode latch
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INIT;
      r_op    <= '0;
    end else begin
      case (r_state)
        S_INIT: r_state <= S_F0;
        S_F0:   r_state <= S_F1;
        S_F1:   r_state <= S_F2;
        S_F2:   r_state <= S_DEC;
        S_DEC: begin
          r_op    <= out_IR;
          r_state <= w_dec.valid ? S_EX : S_F0;
        end
        S_EX:    r_state <= S_F0;
        default: r_state <= S_INIT;
      endcase
    end
  end

  // Moore output decode; while rst is high the INIT values are forced so an
  // in-flight EX write is dropped and ill_op stays low
  always_comb begin
    enaf       = 1'b0;
    selop      = ALU_PASS;
    shamt      = 2'b00;
    bank_wr_en = 1'b0;
    BusB_addr  = '0;
    BusC_addr  = '0;
    sclr       = 1'b0;
    ir_en      = 1'b0;
    mar_en     = 1'b0;
    mdr_en     = 1'b0;
    mdr_alu_n  = 1'b0;
    wr_rdn     = 1'b0;
    ill_op     = 1'b0;
    if (rst) begin
      sclr = 1'b1;
    end else begin
      case (r_state)
        S_INIT: sclr = 1'b1;
        S_F0: begin
          BusB_addr = ADDR_WIDTH'(REG_PC);
          mar_en    = 1'b1;
        end
        S_F1: begin
          mdr_en     = 1'b1;
          BusB_addr  = ADDR_WIDTH'(REG_PC);
          BusC_addr  = ADDR_WIDTH'(REG_PC);
          selop      = ALU_INC;
          bank_wr_en = 1'b1;
        end
        S_F2: ir_en = 1'b1;
        S_DEC: ill_op = ~w_dec.valid;
        S_EX: begin
          selop      = w_dec.selop;
          shamt      = w_dec.shamt;
          BusB_addr  = ADDR_WIDTH'(w_dec.busb);
          BusC_addr  = ADDR_WIDTH'(w_dec.busc);
          bank_wr_en = w_dec.write & w_take;
          enaf       = w_dec.enaf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pdua_ctrl_unit.sv
// Directed bench for pdua_ctrl_unit with hand-computed expectations.
module tb_pdua_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] out_IR;
  logic       C, N, P, Z;
  logic       enaf, bank_wr_en, sclr, ir_en, mar_en, mdr_en, mdr_alu_n, wr_rdn, ill_op;
  logic [2:0] selop;
  logic [1:0] shamt;
  logic [2:0] BusB_addr, BusC_addr;

  int n_cmp = 0;
  int n_bad = 0;

  pdua_ctrl_unit #(.ADDR_WIDTH(3), .OP_WIDTH(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .out_IR     (out_IR),
    .C          (C),
    .N          (N),
    .P          (P),
    .Z          (Z),
    .enaf       (enaf),
    .selop      (selop),
    .shamt      (shamt),
    .bank_wr_en (bank_wr_en),
    .BusB_addr  (BusB_addr),
    .BusC_addr  (BusC_addr),
    .sclr       (sclr),
    .ir_en      (ir_en),
    .mar_en     (mar_en),
    .mdr_en     (mdr_en),
    .mdr_alu_n  (mdr_alu_n),
    .wr_rdn     (wr_rdn),
    .ill_op     (ill_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // From F0: walk F1, F2 (presenting the opcode and flags), stop in DEC
  task automatic to_dec(input logic [4:0] op, input logic z, input logic n);
    tick;
    out_IR = op;
    Z      = z;
    N      = n;
    tick;
    tick;
  endtask

  initial begin
    rst = 1'b1; out_IR = '0; C = 1'b0; N = 1'b0; P = 1'b0; Z = 1'b0;
    tick; tick;
    chk("rst_sclr",   32'(sclr),       1);
    chk("rst_ill",    32'(ill_op),     0);
    chk("rst_wr",     32'(bank_wr_en), 0);
    chk("rst_mar",    32'(mar_en),     0);

    rst = 1'b0; #1;
    chk("init_sclr",  32'(sclr),       1);
    chk("init_ill",   32'(ill_op),     0);

    tick; // F0
    chk("f0_mar",     32'(mar_en),     1);
    chk("f0_busb",    32'(BusB_addr),  0);
    chk("f0_sclr",    32'(sclr),       0);
    tick; // F1
    chk("f1_mdr",     32'(mdr_en),     1);
    chk("f1_wr",      32'(bank_wr_en), 1);
    chk("f1_selop",   32'(selop),      3'b010);
    chk("f1_busc",    32'(BusC_addr),  0);
    chk("f1_enaf",    32'(enaf),       0);
    chk("f1_wrrd",    32'(wr_rdn),     0);
    out_IR = 5'b00011;
    tick; // F2
    chk("f2_ir",      32'(ir_en),      1);
    chk("f2_wr",      32'(bank_wr_en), 0);
    tick; // DEC
    chk("xor_dec_ill", 32'(ill_op),    0);
    chk("xor_dec_enaf", 32'(enaf),     0);
    tick; // EX
    chk("xor_selop",  32'(selop),      3'b100);
    chk("xor_busb",   32'(BusB_addr),  3);
    chk("xor_busc",   32'(BusC_addr),  7);
    chk("xor_wr",     32'(bank_wr_en), 1);
    chk("xor_enaf",   32'(enaf),       1);
    tick; // F0 again: 5-cycle period
    chk("per_mar",    32'(mar_en),     1);

    // JZ taken
    to_dec(5'b00111, 1'b1, 1'b0);
    tick;
    chk("jz1_wr",     32'(bank_wr_en), 1);
    chk("jz1_busb",   32'(BusB_addr),  2);
    chk("jz1_busc",   32'(BusC_addr),  0);
    chk("jz1_enaf",   32'(enaf),       0);
    tick;

    // JZ not taken
    to_dec(5'b00111, 1'b0, 1'b0);
    tick;
    chk("jz0_wr",     32'(bank_wr_en), 0);
    tick;
    chk("jz0_f0_mar", 32'(mar_en),     1);
    chk("jz0_f0_busb", 32'(BusB_addr), 0);

    // JN taken (highest defined opcode)
    to_dec(5'b01000, 1'b0, 1'b1);
    chk("jn_dec_ill", 32'(ill_op),     0);
    tick;
    chk("jn_wr",      32'(bank_wr_en), 1);
    chk("jn_busb",    32'(BusB_addr),  2);
    tick;

    // SHL ACC
    to_dec(5'b00101, 1'b0, 1'b0);
    tick;
    chk("shl_selop",  32'(selop),      3'b101);
    chk("shl_shamt",  32'(shamt),      1);
    chk("shl_busc",   32'(BusC_addr),  7);
    chk("shl_wr",     32'(bank_wr_en), 1);
    chk("shl_enaf",   32'(enaf),       1);
    tick;

    // MOV A,ACC
    to_dec(5'b00010, 1'b0, 1'b0);
    tick;
    chk("mova_busb",  32'(BusB_addr),  7);
    chk("mova_busc",  32'(BusC_addr),  3);
    chk("mova_wr",    32'(bank_wr_en), 1);
    chk("mova_enaf",  32'(enaf),       0);
    tick;

    // Illegal 11111: 4-cycle instruction
    to_dec(5'b11111, 1'b0, 1'b0);
    chk("ill31_pulse", 32'(ill_op),    1);
    chk("ill31_wr",   32'(bank_wr_en), 0);
    tick;
    chk("ill31_after", 32'(ill_op),    0);
    chk("ill31_f0",   32'(mar_en),     1);
    chk("ill31_f0wr", 32'(bank_wr_en), 0);

    // Illegal 01001: first undefined opcode
    to_dec(5'b01001, 1'b0, 1'b0);
    chk("ill9_pulse", 32'(ill_op),     1);
    tick;
    chk("ill9_f0",    32'(mar_en),     1);

    // ADD interrupted by reset in EX
    to_dec(5'b00100, 1'b0, 1'b0);
    tick;
    chk("add_selop",  32'(selop),      3'b001);
    chk("add_wr",     32'(bank_wr_en), 1);
    rst = 1'b1; #1;
    chk("addrst_wr",  32'(bank_wr_en), 0);
    chk("addrst_sclr", 32'(sclr),      1);
    chk("addrst_enaf", 32'(enaf),      0);
    #1;
    tick;
    rst = 1'b0; #1;
    chk("addrst_init", 32'(sclr),      1);
    chk("addrst_ill", 32'(ill_op),     0);
    tick;
    chk("addrst_f0",  32'(mar_en),     1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
